// File: rtl/ex_div_if.sv
// Request/response bundle between the EX stage (master) and the iterative divider (slave).
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per clock.
// Define DIV_SIGNED_EN to build in signed (DIV) support; without it every division is unsigned.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst,
    ex_div_if.slave div
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    // Upper half holds the partial remainder, lower half the unconsumed dividend bits
    // with quotient bits filling in from the right.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   divisor;
    logic [2*WIDTH-1:0] result;
    logic               ready;

    logic               accept;
    logic [WIDTH-1:0]   op1_mag;
    logic [WIDTH-1:0]   op2_mag;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     part;
    logic               fits;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] final_result;

    assign accept   = div.start_i && !div.annul_i;
    assign shifted  = {acc, 1'b0};
    assign part     = shifted[2*WIDTH:WIDTH];
    assign fits     = part >= {1'b0, divisor};
    // part < 2*divisor always, so the difference fits in WIDTH bits.
    assign acc_next = fits ? {part[WIDTH-1:0] - divisor, shifted[WIDTH-1:1], 1'b1}
                           : shifted[2*WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    logic op1_neg;
    logic op2_neg;
    logic neg_quo;
    logic neg_rem;

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign op1_neg      = div.signed_div_i & div.opdata1_i[WIDTH-1];
    assign op2_neg      = div.signed_div_i & div.opdata2_i[WIDTH-1];
    assign op1_mag      = negate_if(div.opdata1_i, op1_neg);
    assign op2_mag      = negate_if(div.opdata2_i, op2_neg);
    // Remainder follows the dividend's sign; MIN/-1 wraps back to MIN naturally.
    assign final_result = {negate_if(acc_next[2*WIDTH-1:WIDTH], neg_rem),
                           negate_if(acc_next[WIDTH-1:0], neg_quo)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (state == DivFree && accept) begin
            neg_quo <= op1_neg ^ op2_neg;
            neg_rem <= op1_neg;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = div.signed_div_i;
    assign op1_mag       = div.opdata1_i;
    assign op2_mag       = div.opdata2_i;
    assign final_result  = acc_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DivFree;
            cnt     <= '0;
            acc     <= '0;
            divisor <= '0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                DivFree: begin
                    ready <= 1'b0;
                    if (accept) begin
                        if (div.opdata2_i == '0) begin
                            state <= DivByZero;
                        end else begin
                            state   <= DivOn;
                            cnt     <= '0;
                            acc     <= {{WIDTH{1'b0}}, op1_mag};
                            divisor <= op2_mag;
                        end
                    end
                end
                DivByZero: begin
                    if (div.annul_i) begin
                        state <= DivFree;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end else begin
                        state  <= DivEnd;
                        result <= '0;
                        ready  <= 1'b1;
                    end
                end
                DivOn: begin
                    if (div.annul_i) begin
                        state <= DivFree;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state  <= DivEnd;
                            result <= final_result;
                            ready  <= 1'b1;
                        end
                    end
                end
                DivEnd: begin
                    if (!div.start_i) begin
                        state  <= DivFree;
                        result <= '0;
                        ready  <= 1'b0;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

    assign div.result_o = result;
    assign div.ready_o  = ready;
endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: a cycle-level reference model compared every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_ex_div;
    localparam int W = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_div_if #(.WIDTH(W)) bus ();
    ex_div #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .div(bus));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: SV '/' and '%' truncate toward zero, remainder takes dividend sign.
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn && SIGNED_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Cycle-level behaviour: idle -> busy (32 cycles, or 1 for a zero divisor) -> done.
    int          m_phase;
    int          m_left;
    logic [63:0] m_pend;
    logic [63:0] exp_result;
    logic        exp_ready;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase    <= 0;
            m_left     <= 0;
            m_pend     <= 64'd0;
            exp_ready  <= 1'b0;
            exp_result <= 64'd0;
        end else begin
            case (m_phase)
                0: if (bus.start_i && !bus.annul_i) begin
                    m_pend  <= model_div(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i);
                    m_left  <= (bus.opdata2_i == 32'd0) ? 1 : 32;
                    m_phase <= 1;
                end
                1: if (bus.annul_i) begin
                    m_phase <= 0;
                end else if (m_left == 1) begin
                    m_phase    <= 2;
                    exp_ready  <= 1'b1;
                    exp_result <= m_pend;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (!bus.start_i) begin
                    m_phase    <= 0;
                    exp_ready  <= 1'b0;
                    exp_result <= 64'd0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc ready", {63'd0, bus.ready_o}, {63'd0, exp_ready});
            check("cyc result", bus.result_o, exp_result);
        end
    end

    task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = sgn;
        bus.start_i      = 1'b1;
    endtask

    // Counts edges from the acceptance edge until ready is seen.
    task automatic wait_ready(input string name, input int exp_lat);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.ready_o && n < 100);
        check({name, " latency"}, 64'(n - 1), 64'(exp_lat));
    endtask

    task automatic end_div(input string name);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " ready drop"}, {63'd0, bus.ready_o}, 64'd0);
        check({name, " result clr"}, bus.result_o, 64'd0);
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp);
        start_div(a, b, sgn);
        wait_ready(name, (b == 32'd0) ? 1 : 32);
        check({name, " result"}, bus.result_o, exp);
        end_div(name);
    endtask

    initial begin
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        #3 rst = 1'b0;
        #1;
        check("reset ready", {63'd0, bus.ready_o}, 64'd0);
        check("reset result", bus.result_o, 64'd0);
        chk_en = 1'b1;
        #12 rst = 1'b1;
        @(posedge clk);
        #1;

        run_div("u100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
        run_div("div0", 32'h12345678, 32'd0, 1'b0, 64'd0);
        run_div("u3/10", 32'd3, 32'd10, 1'b0, {32'd3, 32'd0});
        run_div("umax/max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, {32'd0, 32'd1});
        run_div("umax/1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF});
        run_div("u-7/2", 32'hFFFFFFF9, 32'd2, 1'b0, {32'd1, 32'h7FFFFFFC});
        run_div("s-7/2", 32'hFFFFFFF9, 32'd2, 1'b1,
                SIGNED_EN ? {32'hFFFFFFFF, 32'hFFFFFFFD} : {32'd1, 32'h7FFFFFFC});
        run_div("smin/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1,
                SIGNED_EN ? {32'd0, 32'h80000000} : {32'h80000000, 32'd0});
        run_div("s7/-2", 32'd7, 32'hFFFFFFFE, 1'b1,
                SIGNED_EN ? {32'd1, 32'hFFFFFFFD} : {32'd7, 32'd0});

        // Annul after 10 steps, then a fresh request on the following cycle.
        start_div(32'd100, 32'd7, 1'b0);
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 bus.annul_i = 1'b1;
        @(posedge clk);
        #1 bus.annul_i = 1'b0;
        check("annul ready", {63'd0, bus.ready_o}, 64'd0);
        run_div("9/3 after annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

        // Asynchronous reset 15 steps into a division.
        start_div(32'd1000, 32'd3, 1'b0);
        @(posedge clk);
        repeat (15) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst ready", {63'd0, bus.ready_o}, 64'd0);
        check("midrst result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        #10 rst = 1'b1;
        @(posedge clk);
        #1;
        run_div("50/5 after rst", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10});

        // Hold in the done state while operands wander, then reset while holding.
        start_div(32'hFFFFFFFF, 32'd3, 1'b0);
        wait_ready("hold", 32);
        for (int i = 0; i < 20; i++) begin
            bus.opdata1_i = $urandom;
            bus.opdata2_i = $urandom;
            @(posedge clk);
            #1;
            check("hold result", bus.result_o, {32'd0, 32'h55555555});
            check("hold ready", {63'd0, bus.ready_o}, 64'd1);
        end
        #2 rst = 1'b0;
        #1;
        check("endrst ready", {63'd0, bus.ready_o}, 64'd0);
        check("endrst result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        run_div("6/4 final", 32'd6, 32'd4, 1'b0, {32'd2, 32'd1});

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
